// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - opcode, state and control-bundle definitions for the instruction sequencer
package cpu_defs;

  localparam int OP_W = 3;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [8:0] {
    S0     = 9'b000000001,
    S1     = 9'b000000010,
    S2     = 9'b000000100,
    S3     = 9'b000001000,
    S4     = 9'b000010000,
    S5     = 9'b000100000,
    S6     = 9'b001000000,
    S7     = 9'b010000000,
    HALTED = 9'b100000000
  } state_t;

  typedef struct packed {
    logic inc_pc;
    logic load_pc;
    logic load_ir;
    logic load_acc;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic halt;
  } ctl_t;

endpackage

// File: rtl/op_decode.sv
// rtl/op_decode.sv - combinational opcode class decoder
module op_decode #(
  parameter int OP_W = 3
) (
  input  logic [OP_W-1:0] op,
  output logic            is_hlt,
  output logic            is_skz,
  output logic            is_jmp,
  output logic            is_sto,
  output logic            is_alu
);
  import cpu_defs::*;

  // ALU class covers every opcode that reads an operand from memory into the accumulator
  always_comb begin
    is_hlt = (op == OP_W'(OP_HLT));
    is_skz = (op == OP_W'(OP_SKZ));
    is_jmp = (op == OP_W'(OP_JMP));
    is_sto = (op == OP_W'(OP_STO));
    is_alu = (op == OP_W'(OP_ADD)) || (op == OP_W'(OP_AND)) ||
             (op == OP_W'(OP_XOR)) || (op == OP_W'(OP_LDA));
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - 8-step fetch/decode/execute strobe sequencer with halt
module instr_sequencer #(
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic            inc_pc,
  output logic            load_pc,
  output logic            load_ir,
  output logic            load_acc,
  output logic            rd,
  output logic            wr,
  output logic            datactl_ena,
  output logic            halt
);
  import cpu_defs::*;

  state_t          state, state_n;
  logic            run_q, run_n;   // 0 while parked in S0 (after reset or ena low)
  logic            skip_q;
  logic [OP_W-1:0] op_q;
  ctl_t            ctl_q, ctl_n;

  logic is_hlt, is_skz, is_jmp, is_sto, is_alu;

  op_decode #(.OP_W(OP_W)) u_op_decode (
    .op     (op_q),
    .is_hlt (is_hlt),
    .is_skz (is_skz),
    .is_jmp (is_jmp),
    .is_sto (is_sto),
    .is_alu (is_alu)
  );

  // Next state plus the strobes for that state, so registered outputs line up with state
  always_comb begin
    state_n = S0;
    run_n   = 1'b0;
    ctl_n   = '0;

    case (state)
      S0: if (ena) begin run_n = 1'b1; state_n = run_q ? S1 : S0; end
      S1: if (ena) begin run_n = 1'b1; state_n = S2; end
      S2: if (ena) begin run_n = 1'b1; state_n = S3; end
      S3: if (ena) begin
            if (is_hlt) begin
              state_n = HALTED;
            end else begin
              run_n   = 1'b1;
              state_n = S4;
            end
          end
      S4: if (ena) begin run_n = 1'b1; state_n = S5; end
      S5: if (ena) begin run_n = 1'b1; state_n = S6; end
      S6: if (ena) begin run_n = 1'b1; state_n = S7; end
      S7: if (ena) begin run_n = 1'b1; state_n = S0; end
      HALTED: state_n = HALTED;
      default: ;
    endcase

    case (state_n)
      S0, S1: if (run_n) begin
                ctl_n.load_ir = 1'b1;
                ctl_n.rd      = 1'b1;
                ctl_n.inc_pc  = 1'b1;
              end
      S4: if (run_n) begin
            ctl_n.rd          = is_alu;
            ctl_n.datactl_ena = is_sto;
            ctl_n.load_pc     = is_jmp;
          end
      S5: if (run_n) begin
            ctl_n.rd          = is_alu;
            ctl_n.load_acc    = is_alu;
            ctl_n.datactl_ena = is_sto;
            ctl_n.wr          = is_sto;
            ctl_n.load_pc     = is_jmp;
          end
      S6: if (run_n) begin
            ctl_n.rd          = is_alu;
            ctl_n.datactl_ena = is_sto;
          end
      S7: if (run_n) begin
            ctl_n.inc_pc = is_skz && skip_q;
          end
      HALTED: ctl_n.halt = 1'b1;
      default: ;
    endcase
  end

  // State, opcode latch, skip flag and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S0;
      run_q  <= 1'b0;
      op_q   <= '0;
      skip_q <= 1'b0;
      ctl_q  <= '0;
    end else begin
      state <= state_n;
      run_q <= run_n;
      ctl_q <= ctl_n;
      if (state == S2 && state_n == S3) begin
        op_q   <= opcode;
        skip_q <= 1'b0;
      end
      if (state == S4 && state_n == S5 && is_skz) begin
        skip_q <= zero;
      end
    end
  end

  assign inc_pc      = ctl_q.inc_pc;
  assign load_pc     = ctl_q.load_pc;
  assign load_ir     = ctl_q.load_ir;
  assign load_acc    = ctl_q.load_acc;
  assign rd          = ctl_q.rd;
  assign wr          = ctl_q.wr;
  assign datactl_ena = ctl_q.datactl_ena;
  assign halt        = ctl_q.halt;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard testbench for instr_sequencer
module tb_instr_sequencer;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

  logic       clk = 1'b0;
  logic       rst, ena, zero;
  logic [2:0] opcode;
  logic       inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt;

  typedef struct {
    logic [7:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   fails  = 0;

  instr_sequencer #(.OP_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .opcode      (opcode),
    .zero        (zero),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_ir     (load_ir),
    .load_acc    (load_acc),
    .rd          (rd),
    .wr          (wr),
    .datactl_ena (datactl_ena),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  // bits: inc_pc load_pc load_ir load_acc rd wr datactl_ena halt
  function automatic logic [7:0] obs();
    return {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt};
  endfunction

  // Expected strobes for step st of an instruction with opcode op
  function automatic logic [7:0] model(int st, logic [2:0] op, logic skip);
    logic [7:0] v;
    logic       alu;
    v   = 8'h00;
    alu = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
    case (st)
      0, 1: v = 8'b1010_1000;
      4: begin
        if (alu) v[3] = 1'b1;
        if (op == STO) v[1] = 1'b1;
        if (op == JMP) v[6] = 1'b1;
      end
      5: begin
        if (alu) begin v[4] = 1'b1; v[3] = 1'b1; end
        if (op == STO) begin v[2] = 1'b1; v[1] = 1'b1; end
        if (op == JMP) v[6] = 1'b1;
      end
      6: begin
        if (alu) v[3] = 1'b1;
        if (op == STO) v[1] = 1'b1;
      end
      7: if (op == SKZ && skip) v[7] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic void push(logic [7:0] v, string tag);
    exp_t x;
    x.v   = v;
    x.tag = tag;
    sb.push_back(x);
  endfunction

  // Strobe invariants checked every cycle once out of reset
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ((rd && wr) || (wr && !datactl_ena) || (load_pc && inc_pc)) begin
        fails++;
        $display("FAIL invariant: got rd=%b wr=%b dc=%b load_pc=%b inc_pc=%b required exclusive strobes",
                 rd, wr, datactl_ena, load_pc, inc_pc);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; opcode = ADD; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push(8'h00, "reset");
      @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
    end
    rst = 1'b0;
    push(8'h00, "parked");
    @(posedge clk); #1; e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
  endtask

  task automatic test_alu();
    logic [2:0] ops [5];
    ops = '{ADD, ADD, AND_, XOR_, LDA};
    ena = 1'b1;
    foreach (ops[k]) begin
      opcode = ops[k];
      for (int st = 0; st < 8; st++) begin
        push(model(st, ops[k], 1'b0), $sformatf("alu op%0d S%0d", ops[k], st));
        @(posedge clk); #1; e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
      end
    end
  endtask

  task automatic test_sto();
    opcode = STO;
    for (int st = 0; st < 8; st++) begin
      push(model(st, STO, 1'b0), $sformatf("sto S%0d", st));
      @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
    end
  endtask

  task automatic test_skz();
    logic zs [2];
    zs = '{1'b1, 1'b0};
    opcode = SKZ;
    foreach (zs[k]) begin
      zero = ~zs[k];
      for (int st = 0; st < 8; st++) begin
        push(model(st, SKZ, zs[k]), $sformatf("skz z%0b S%0d", zs[k], st));
        @(posedge clk); #1; e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
        if (st == 3) zero = zs[k];
        if (st == 5 || st == 6) zero = ~zero;
      end
    end
  endtask

  task automatic test_jmp();
    opcode = JMP;
    for (int st = 0; st < 8; st++) begin
      push(model(st, JMP, 1'b0), $sformatf("jmp S%0d", st));
      @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    for (int n = 0; n < 8; n++) begin
      op     = 3'($urandom_range(1, 7));
      opcode = op;
      zero   = 1'($urandom_range(0, 1));
      for (int st = 0; st < 8; st++) begin
        push(model(st, op, zero), $sformatf("b2b%0d op%0d S%0d", n, op, st));
        @(posedge clk); #1; e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
        if (st == 3) opcode = 3'($urandom_range(0, 7));
      end
    end
  endtask

  task automatic test_ena_abort();
    opcode = STO;
    for (int st = 0; st < 5; st++) begin
      push(model(st, STO, 1'b0), $sformatf("abort pre S%0d", st));
      @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
    end
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(8'h00, $sformatf("abort ena low %0d", i));
      @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
    end
    ena = 1'b1;
    for (int st = 0; st < 8; st++) begin
      push(model(st, STO, 1'b0), $sformatf("abort resume S%0d", st));
      @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
    end
  endtask

  task automatic test_halt();
    opcode = HLT;
    for (int st = 0; st < 4; st++) begin
      push(model(st, HLT, 1'b0), $sformatf("hlt S%0d", st));
      @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
    end
    push(8'h01, "halt entry");
    @(posedge clk); #1; e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
    opcode = ADD;
    for (int i = 0; i < 20; i++) begin
      ena = 1'($urandom_range(0, 1));
      push(8'h01, $sformatf("halt held %0d", i));
      @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
    end
    rst = 1'b1;
    push(8'h00, "halt reset");
    @(posedge clk); #1; e = sb.pop_front(); checks++;
    if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
    rst = 1'b0; ena = 1'b1;
    for (int st = 0; st < 8; st++) begin
      push(model(st, ADD, 1'b0), $sformatf("post-halt S%0d", st));
      @(posedge clk); #1; e = sb.pop_front(); checks++;
      if (obs() !== e.v) begin fails++; $display("FAIL %s: got %b required %b", e.tag, obs(), e.v); end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; opcode = ADD; zero = 1'b0;
    test_reset();
    test_alu();
    test_sto();
    test_skz();
    test_jmp();
    test_back_to_back();
    test_ena_abort();
    test_halt();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: got %0d entries required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
